// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - frame scheduler for Transmit gates; `FRAME_INTERLEAVE_EN selects even/odd line order
module scan_sequencer #(
    parameter int LINE_COUNT  = 256,
    parameter int FOCUS_COUNT = 3,
    parameter int PR_CYCLES   = 2000,
    parameter int RX_CYCLES   = 20000,
    parameter int END_CYCLES  = 100,
    parameter int GAP_CYCLES  = 50
) (
    input  logic       clk_100M,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    output logic [7:0] Line_Num,
    output logic [1:0] Focus_Num,
    output logic       Pr_Gate,
    output logic       RX_Gate,
    output logic       End_Gate,
    output logic       Envelop,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RX, S_END, S_GAP} state_t;

    localparam logic [15:0] PR_LOAD    = 16'(PR_CYCLES - 1);
    localparam logic [15:0] RX_LOAD    = 16'(RX_CYCLES - 1);
    localparam logic [15:0] END_LOAD   = 16'(END_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic [8:0]  LINE_LAST  = 9'(LINE_COUNT - 1);
    localparam logic [1:0]  FOCUS_LAST = 2'(FOCUS_COUNT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [8:0]  line_idx;
    logic        stop_pending;
    logic [8:0]  line_next;
    logic        line_last;
    logic        focus_last;
    logic        frame_end;
    logic        adv;
    logic        halt;

    assign Line_Num   = line_idx[7:0];
    assign focus_last = (Focus_Num == FOCUS_LAST);
    assign frame_end  = focus_last && line_last;
    assign adv        = (cnt == 16'd0) &&
                        ((state == S_GAP) || ((state == S_END) && (GAP_CYCLES == 0)));
    // A stop pulse landing on the advance cycle itself still halts this firing.
    assign halt       = stop_pending || stop || (frame_end && !continuous);

`ifdef FRAME_INTERLEAVE_EN
    always_comb begin
        line_next = 9'd0;
        line_last = 1'b0;
        if ((line_idx + 9'd2) <= LINE_LAST) begin
            line_next = line_idx + 9'd2;
        end else if (!line_idx[0] && (LINE_COUNT > 1)) begin
            line_next = 9'd1;
        end else begin
            line_last = 1'b1;
        end
    end
`else
    always_comb begin
        line_last = (line_idx == LINE_LAST);
        line_next = line_last ? 9'd0 : line_idx + 9'd1;
    end
`endif

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            line_idx     <= 9'd0;
            Focus_Num    <= 2'd0;
            stop_pending <= 1'b0;
            Pr_Gate      <= 1'b0;
            RX_Gate      <= 1'b0;
            End_Gate     <= 1'b0;
            Envelop      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    stop_pending <= 1'b0;
                    if (start && !stop) begin
                        state     <= S_PREP;
                        cnt       <= PR_LOAD;
                        line_idx  <= 9'd0;
                        Focus_Num <= 2'd0;
                        Pr_Gate   <= 1'b1;
                        Envelop   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_PREP: begin
                    stop_pending <= stop_pending | stop;
                    if (cnt == 16'd0) begin
                        state   <= S_RX;
                        cnt     <= RX_LOAD;
                        Pr_Gate <= 1'b0;
                        RX_Gate <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_RX: begin
                    stop_pending <= stop_pending | stop;
                    if (cnt == 16'd0) begin
                        state    <= S_END;
                        cnt      <= END_LOAD;
                        RX_Gate  <= 1'b0;
                        End_Gate <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_END: begin
                    stop_pending <= stop_pending | stop;
                    if (cnt == 16'd0) begin
                        state    <= S_GAP;
                        cnt      <= GAP_LOAD;
                        End_Gate <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_GAP: begin
                    stop_pending <= stop_pending | stop;
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Advance step overrides the phase logic above on the firing's last cycle.
            if (adv) begin
                if (!focus_last) begin
                    Focus_Num <= Focus_Num + 2'd1;
                end else begin
                    Focus_Num <= 2'd0;
                    line_idx  <= line_last ? 9'd0 : line_next;
                end
                frame_done <= frame_end;
                if (halt) begin
                    state        <= S_IDLE;
                    Envelop      <= 1'b0;
                    busy         <= 1'b0;
                    stop_pending <= 1'b0;
                    line_idx     <= 9'd0;
                    Focus_Num    <= 2'd0;
                end else begin
                    state   <= S_PREP;
                    cnt     <= PR_LOAD;
                    Pr_Gate <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized self-checking bench for scan_sequencer
module tb_scan_sequencer;

    localparam int PR   = 4;
    localparam int RX   = 8;
    localparam int EN   = 2;
    localparam int GP   = 2;
    localparam int FIRE = PR + RX + EN + GP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, stop, continuous;
    logic       start_b, stop_b, continuous_b;
    logic [7:0] line_a, line_b;
    logic [1:0] focus_a, focus_b;
    logic       pr_a, rx_a, end_a, env_a, busy_a, fd_a;
    logic       pr_b, rx_b, end_b, env_b, busy_b, fd_b;

    scan_sequencer #(
        .LINE_COUNT(4), .FOCUS_COUNT(3), .PR_CYCLES(PR), .RX_CYCLES(RX),
        .END_CYCLES(EN), .GAP_CYCLES(GP)
    ) dut_a (
        .clk_100M(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .continuous(continuous), .Line_Num(line_a), .Focus_Num(focus_a),
        .Pr_Gate(pr_a), .RX_Gate(rx_a), .End_Gate(end_a), .Envelop(env_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    scan_sequencer #(
        .LINE_COUNT(5), .FOCUS_COUNT(1), .PR_CYCLES(PR), .RX_CYCLES(RX),
        .END_CYCLES(EN), .GAP_CYCLES(GP)
    ) dut_b (
        .clk_100M(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b),
        .continuous(continuous_b), .Line_Num(line_b), .Focus_Num(focus_b),
        .Pr_Gate(pr_b), .RX_Gate(rx_b), .End_Gate(end_b), .Envelop(env_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_line[$];
    int exp_focus[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {Line, Focus, Pr, RX, End, Envelop, busy, frame_done}
    function automatic logic [15:0] obs(input int sel);
        if (sel == 0) return {line_a, focus_a, pr_a, rx_a, end_a, env_a, busy_a, fd_a};
        return {line_b, focus_b, pr_b, rx_b, end_b, env_b, busy_b, fd_b};
    endfunction

    task automatic build_order(input int nl, input int nf);
        int lines[$];
        exp_line.delete();
        exp_focus.delete();
`ifdef FRAME_INTERLEAVE_EN
        for (int l = 0; l < nl; l += 2) lines.push_back(l);
        for (int l = 1; l < nl; l += 2) lines.push_back(l);
`else
        for (int l = 0; l < nl; l++) lines.push_back(l);
`endif
        foreach (lines[i]) begin
            for (int f = 0; f < nf; f++) begin
                exp_line.push_back(lines[i]);
                exp_focus.push_back(f);
            end
        end
    endtask

    // k counts cycles from the first PREP cycle; act is the number of active cycles
    function automatic logic [15:0] model(input int k, input int act, input int frame_len);
        logic [15:0] v;
        int p, idx;
        v = 16'd0;
        if (k < act) begin
            p   = k % FIRE;
            idx = (k / FIRE) % exp_line.size();
            v[15:8] = 8'(exp_line[idx]);
            v[7:6]  = 2'(exp_focus[idx]);
            v[5]    = (p < PR);
            v[4]    = (p >= PR) && (p < PR + RX);
            v[3]    = (p >= PR + RX) && (p < PR + RX + EN);
            v[2]    = 1'b1;
            v[1]    = 1'b1;
            v[0]    = (k > 0) && (k % frame_len == 0);
        end else if (k == act) begin
            v[0] = (act % frame_len == 0);
        end
        return v;
    endfunction

    task automatic run_scan(input int sel, input int nl, input int nf, input bit cont,
                            input int stop_at, input bit inject);
        int frame_len, act;
        build_order(nl, nf);
        frame_len = nl * nf * FIRE;
        act = (stop_at >= 0) ? (stop_at / FIRE + 1) * FIRE : frame_len;
        if (!cont && act > frame_len) act = frame_len;
        @(negedge clk);
        if (sel == 0) begin
            start = 1'b1;
            continuous = cont;
        end else begin
            start_b = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k <= act + 3; k++) begin
            chk($sformatf("dut%0d cont%0d cycle %0d", sel, cont, k), 32'(obs(sel)),
                32'(model(k, act, frame_len)));
            stop  = (sel == 0) && (k == stop_at) && (k < act);
            start = (sel == 0) && inject && (k < act - 1) && (k != stop_at) &&
                    ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        stop = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        bit c;
        int s;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        start_b = 1'b0;
        stop_b = 1'b0;
        continuous_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dut0", 32'(obs(0)), 32'd0);
        chk("reset dut1", 32'(obs(1)), 32'd0);
        reset_n = 1'b1;

        run_scan(0, 4, 3, 1'b0, -1, 1'b0);
        run_scan(0, 4, 3, 1'b1, 2 * 4 * 3 * FIRE + int'($urandom_range(0, 4 * 3 * FIRE - 1)), 1'b0);
        run_scan(0, 4, 3, 1'b0, 4 * FIRE + PR + int'($urandom_range(0, RX - 1)), 1'b1);

        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (4) begin
            chk("start_with_stop_idle", 32'(obs(0)), 32'd0);
            @(negedge clk);
        end

        start = 1'b1;
        continuous = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("prep_before_reset", 32'(obs(0)), 32'h0026);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_mid_prep", 32'(obs(0)), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            c = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, (c ? 3 : 1) * 4 * 3 * FIRE - 1));
            if (!c && $urandom_range(0, 1) == 1) s = -1;
            run_scan(0, 4, 3, c, s, 1'b1);
        end

        run_scan(1, 5, 1, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Frame-level scheduler that drives the Transmit block's control inputs (Line_Num, Focus_Num, Pr_Gate, RX_Gate) and the End_Gate/Envelop status lines. For each line it steps through every focal zone. Each firing runs a prepare → receive → end → gap sequence. It replaces the free-running test model in bench and product builds, and adds start/stop control and frame-done status.

Parameters:
LINE_COUNT, 256, lines per frame (1..256)
FOCUS_COUNT, 3, focal zones per line (1..3)
PR_CYCLES, 2000, Pr_Gate high time in clk_100M cycles (1..65535)
RX_CYCLES, 20000, RX_Gate high time in cycles (1..65535)
END_CYCLES, 100, End_Gate high time in cycles (1..65535)
GAP_CYCLES, 50, all-gates-low dead time after End_Gate (0..65535)

Ports:
clk_100M  in  1  100 MHz system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin scanning from line 0, focus 0
stop  in  1  one-cycle pulse; graceful halt after the current firing
continuous  in  1  1 = restart a new frame automatically; 0 = single frame; sampled at frame end
Line_Num  out  8  current line index to Transmit
Focus_Num  out  2  current focal zone to Transmit
Pr_Gate  out  1  prepare window
RX_Gate  out  1  transmit/receive window
End_Gate  out  1  end-of-firing window
Envelop  out  1  high for the whole active frame
busy  out  1  high whenever state is not IDLE
frame_done  out  1  one-cycle pulse on completion of the last firing of a frame

Behaviour:
- Reset values: all outputs 0; state IDLE; stop_pending 0; 16-bit cycle counter 0.
- All outputs are registered. Clock and reset are as stated: one clock, clk_100M; reset_n is asynchronous, active-low.
- States are IDLE, PREP, RX, END, GAP.
- IDLE:
  - start=1 and stop=0 → PREP on the next edge.
  - Line_Num and Focus_Num load 0; Envelop goes 1 with Pr_Gate.
  - start together with stop in IDLE is ignored.
- PREP: Pr_Gate=1 for exactly PR_CYCLES cycles, then RX.
- RX: RX_Gate=1 for exactly RX_CYCLES cycles, then END.
- END: End_Gate=1 for exactly END_CYCLES cycles, then GAP. If GAP_CYCLES=0, go straight to the advance step.
- GAP: all gates 0 for GAP_CYCLES cycles, then the advance step.
- Gates are mutually exclusive and contiguous: no idle cycle between PREP→RX or RX→END.
- Advance step, on the last cycle of GAP (or of END when GAP_CYCLES=0):
  - If Focus_Num < FOCUS_COUNT-1: Focus_Num+1, then PREP.
  - Otherwise Focus_Num=0. If line index < LINE_COUNT-1: line index+1, then PREP.
  - Otherwise it is frame end: frame_done pulses for 1 cycle and line index=0.
    - If continuous=1 and stop_pending=0: PREP, Envelop stays 1.
    - Otherwise: IDLE, Envelop=0, busy=0.
- Line_Num and Focus_Num change only at the advance step and are stable across all three gate windows.
- stop:
  - Accepted in any non-IDLE state; sets stop_pending.
  - At the next advance step the block goes to IDLE, whether or not at frame end.
  - On that early stop, frame_done stays 0 unless this was the frame-end firing.
  - Envelop drops with the IDLE transition; stop_pending clears in IDLE.
- start while busy is ignored.
- reset_n asserted mid-firing: all gates drop asynchronously to 0 and state returns to IDLE.
- Cycle counter: 16-bit, loads the phase length minus 1 at phase entry, counts down to 0; the phase ends when it reaches 0.
- Line index counter: 9 bits internally; Line_Num is its low 8 bits.

Optional Feature:
FRAME_INTERLEAVE_EN
- Defined: line order within a frame is interleaved: even lines ascending (0,2,…), then odd lines ascending (1,3,…).
  - For odd LINE_COUNT the even pass includes LINE_COUNT-1.
  - Frame end is after the last odd line, or after the last even line when LINE_COUNT=1.
- Undefined: sequential order 0..LINE_COUNT-1.
- Timing, focus stepping and all handshakes are identical in both builds.

Test Plan:
1. Test parameters: LINE_COUNT=4, FOCUS_COUNT=3, PR=4, RX=8, END=2, GAP=2, continuous=0. Pulse start → Pr_Gate 4 cycles, RX_Gate 8, End_Gate 2, gap 2. (Line,Focus) sequence (0,0),(0,1),(0,2),(1,0)…(3,2). frame_done pulses once, 192 cycles after PREP entry; busy and Envelop then 0.
2. Same parameters, continuous=1 → Line_Num wraps 3→0 with no IDLE cycle. frame_done pulses at cycle 192 and at cycle 384 after PREP entry.
3. Stop pulse during RX of (1,1) → firing (1,1) completes END and GAP, then IDLE; no frame_done; (1,2) never issued.
4. Assert reset_n low during PREP → all outputs 0 immediately; after release, start restarts at (0,0).
5. start while busy, and start together with stop in IDLE → both ignored: sequence undisturbed, state stays IDLE respectively.
6. FRAME_INTERLEAVE_EN defined, LINE_COUNT=5, FOCUS_COUNT=1 → Line_Num order 0,2,4,1,3; frame_done after line 3.
